mc_rsp_model: RTL and testbench
===============================

// Module: mc_rsp_model
// PURPOSE
// - Single-port memory-controller responder: the MC end of the mc_rq_*/mc_rs_* interface that personalities drive.
// - Accepts read and write requests into a DEPTH x 64-bit backing store and returns responses after a fixed latency.
// - Applies request back-pressure, honours response stall, and acknowledges write flushes.
// - Used in block-level benches in place of the platform MC.
// PARAMETERS
// - RTNCTL_WIDTH  32  width of the rtnctl tag, echoed unchanged from request to response
// - AW            10  store address width; DEPTH = 2**AW words, indexed by mc_rq_vadr[AW+2:3]
// - LAT           4   pipeline stages from accept to response-FIFO push; legal range 1..16
// - FIFO_DEPTH    16  response FIFO entries, power of two, >= 4
// PORTS
// - clk                 in   1             clock
// - i_reset             in   1             reset; asynchronous, active-high
// - mc_rq_vld           in   1             request valid
// - mc_rq_cmd           in   3             1 = read, 2 = write; other values are ignored and not accepted
// - mc_rq_scmd          in   4             sub-command; ignored
// - mc_rq_size          in   2             access size; only 3 (8-byte) is legal
// - mc_rq_vadr          in   48            byte address; bits [2:0] ignored
// - mc_rq_rtnctl        in   RTNCTL_WIDTH  request tag
// - mc_rq_data          in   64            write data
// - mc_rq_flush         in   1             one-cycle flush request
// - mc_rq_stall         out  1             back-pressure to the requester
// - mc_rs_vld           out  1             response valid
// - mc_rs_cmd           out  3             2 = read data, 3 = write complete
// - mc_rs_scmd          out  4             always 0
// - mc_rs_rtnctl        out  RTNCTL_WIDTH  echoed tag
// - mc_rs_data          out  64            read data; 0 for write complete
// - mc_rs_stall         in   1             requester stall on responses
// - mc_rs_flush_cmplt   out  1             one-cycle flush acknowledge
// - err_size            out  1             sticky: a request with size != 3 was seen
// - err_ovf             out  1             sticky: a request arrived while full and was dropped
// BEHAVIOUR
// - Reset: every output is 0, the pipeline and FIFO are emptied, all counters are 0, and the flush FSM is IDLE.
//   - Store contents are not reset.
//   - Reset mid-operation discards in-flight requests and a pending flush.
// - Accept: a request is taken in any cycle with mc_rq_vld=1, a legal cmd, and occ < FIFO_DEPTH.
//   - occ = pipeline entries + FIFO entries.
//   - mc_rq_stall is ignored for acceptance. The requester may send 2 more requests after stall rises.
// - Store access happens in the accept cycle.
//   - A write updates the store.
//   - A read samples the store in the same cycle, so read-after-write follows issue order.
//   - A write and a read in consecutive cycles to the same word return the new data.
// - A request with size != 3 is still performed as a full 8-byte access and sets err_size.
// - Stall: mc_rq_stall is registered high whenever occ >= FIFO_DEPTH-2 after the current cycle's updates.
// - Overflow: a request arriving while occ == FIFO_DEPTH is dropped: no store write, no response, err_ovf set.
// - Latency: the accepted entry shifts through LAT stages and is then pushed into the FIFO.
//   - With an empty FIFO and no stall, a request in cycle T gives mc_rs_vld=1 in cycle T+LAT+1.
//   - The pipeline never stalls; occ accounting guarantees a FIFO slot.
// - Response handshake: transfer occurs in any cycle with mc_rs_vld=1 and mc_rs_stall=0, and the FIFO pops.
//   - While mc_rs_stall=1, all mc_rs_* outputs hold their values.
//   - Throughput is one response per cycle; responses come out in accept order.
// - A push into an empty FIFO and a pop in the same cycle are both legal, as are a push and a pop when full.
// - Write counter wcnt (log2(FIFO_DEPTH)+1 bits) counts +1 per accepted write and -1 per transferred write-complete.
// - Flush FSM:
//   - IDLE: on mc_rq_flush go to WAIT.
//   - WAIT: when wcnt == 0 go to DONE.
//   - DONE: mc_rs_flush_cmplt=1 for exactly one cycle, then IDLE.
//   - A flush with wcnt == 0 pulses cmplt 2 cycles later.
//   - A write accepted in the same cycle as the flush is included in it.
//   - A flush arriving in WAIT merges into the current one. A flush arriving in DONE starts a new WAIT.
// TESTING
// - Reset -> all outputs 0. Write 0xDEAD_BEEF to vadr 0x40 with rtnctl 7 at T=0 -> mc_rs_vld at T=5 with cmd 3, rtnctl 7, data 0.
// - Write 0x1234 to 0x48 at T, read 0x48 at T+1 -> read response cmd 2, data 0x1234, arriving in issue order after the write-complete.
// - 16 back-to-back reads with mc_rs_stall held 1 -> mc_rq_stall high once occ >= 14. Release stall -> 16 responses on consecutive cycles, outputs held during stall.
// - Ignore stall and issue 17 reads with mc_rs_stall=1 -> the 17th read is dropped, err_ovf=1, exactly 16 responses.
// - 3 writes then mc_rq_flush with mc_rs_stall=1 -> no cmplt. Release stall -> cmplt pulses once, 1 cycle after the 3rd write-complete transfers.
// - Flush with no writes outstanding -> cmplt at T+2. Assert i_reset during the WAIT state -> cmplt never pulses, all outputs 0.

Source files
------------

// File: rtl/mc_rsp_model_if.sv
// Request/response bus between a personality (master) and the
// memory-controller responder (slave).
interface mc_rsp_model_if #(
    parameter int RTNCTL_WIDTH = 32
);
    logic                    mc_rq_vld;
    logic [2:0]              mc_rq_cmd;
    logic [3:0]              mc_rq_scmd;
    logic [1:0]              mc_rq_size;
    logic [47:0]             mc_rq_vadr;
    logic [RTNCTL_WIDTH-1:0] mc_rq_rtnctl;
    logic [63:0]             mc_rq_data;
    logic                    mc_rq_flush;
    logic                    mc_rq_stall;
    logic                    mc_rs_vld;
    logic [2:0]              mc_rs_cmd;
    logic [3:0]              mc_rs_scmd;
    logic [RTNCTL_WIDTH-1:0] mc_rs_rtnctl;
    logic [63:0]             mc_rs_data;
    logic                    mc_rs_stall;
    logic                    mc_rs_flush_cmplt;
    logic                    err_size;
    logic                    err_ovf;

    // Personality side: issues requests, consumes responses.
    modport master (
        output mc_rq_vld, mc_rq_cmd, mc_rq_scmd, mc_rq_size, mc_rq_vadr,
               mc_rq_rtnctl, mc_rq_data, mc_rq_flush, mc_rs_stall,
        input  mc_rq_stall, mc_rs_vld, mc_rs_cmd, mc_rs_scmd, mc_rs_rtnctl,
               mc_rs_data, mc_rs_flush_cmplt, err_size, err_ovf
    );

    // Memory-controller side: services requests, produces responses.
    modport slave (
        input  mc_rq_vld, mc_rq_cmd, mc_rq_scmd, mc_rq_size, mc_rq_vadr,
               mc_rq_rtnctl, mc_rq_data, mc_rq_flush, mc_rs_stall,
        output mc_rq_stall, mc_rs_vld, mc_rs_cmd, mc_rs_scmd, mc_rs_rtnctl,
               mc_rs_data, mc_rs_flush_cmplt, err_size, err_ovf
    );
endinterface

// File: rtl/mc_rsp_model.sv
// Single-port memory-controller responder model. Requests access a
// 64-bit backing store in the accept cycle, travel through a fixed
// LAT-stage pipeline, and land in a response FIFO drained under
// mc_rs_stall. A write counter drives the flush-acknowledge FSM.
module mc_rsp_model #(
    parameter int RTNCTL_WIDTH = 32,
    parameter int AW           = 10,
    parameter int LAT          = 4,
    parameter int FIFO_DEPTH   = 16
) (
    input logic           clk,
    input logic           i_reset,
    mc_rsp_model_if.slave bus
);

    localparam int DEPTH = 2 ** AW;
    localparam int PW    = $clog2(FIFO_DEPTH);

    // Occupancy limits: full means no further request may be taken;
    // the stall threshold leaves room for two requests already in flight.
    localparam logic [PW:0] FULL_OCC  = (PW + 1)'(FIFO_DEPTH);
    localparam logic [PW:0] STALL_OCC = (PW + 1)'(FIFO_DEPTH - 2);

    typedef struct packed {
        logic                    wr;
        logic [RTNCTL_WIDTH-1:0] tag;
        logic [63:0]             data;
    } entry_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } flush_state_t;

    logic [63:0]     store [DEPTH];
    logic [AW-1:0]   addr;
    logic            is_wr;
    logic            req;
    logic            accept;
    logic            drop;
    entry_t          new_entry;

    logic [LAT-1:0]  pipe_vld;
    entry_t          pipe_ent [LAT];

    entry_t          fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [PW:0]     fifo_cnt;
    entry_t          head;
    logic            rs_vld;
    logic            push;
    logic            pop;

    logic [PW:0]     occ;
    logic [PW:0]     occ_next;
    logic [PW:0]     wcnt;
    logic [PW:0]     wcnt_next;

    logic            rq_stall_q;
    logic            err_size_q;
    logic            err_ovf_q;

    flush_state_t    state;
    flush_state_t    state_next;

    logic            unused_bits;

    // Request decode, acceptance and the same-cycle store read.
    always_comb begin
        is_wr     = 1'b0;
        req       = 1'b0;
        accept    = 1'b0;
        drop      = 1'b0;
        addr      = bus.mc_rq_vadr[AW+2:3];
        new_entry = '0;
        is_wr     = (bus.mc_rq_cmd == 3'd2);
        req       = bus.mc_rq_vld && !i_reset &&
                    ((bus.mc_rq_cmd == 3'd1) || (bus.mc_rq_cmd == 3'd2));
        accept    = req && (occ < FULL_OCC);
        drop      = req && (occ >= FULL_OCC);
        new_entry.wr   = is_wr;
        new_entry.tag  = bus.mc_rq_rtnctl;
        new_entry.data = is_wr ? 64'd0 : store[addr];
    end

    // Response FIFO head, handshake and the occupancy/write bookkeeping.
    always_comb begin
        head      = fifo_mem[rd_ptr];
        rs_vld    = (fifo_cnt != '0);
        push      = pipe_vld[LAT-1];
        pop       = rs_vld && !bus.mc_rs_stall;
        occ_next  = occ + {{PW{1'b0}}, accept} - {{PW{1'b0}}, pop};
        wcnt_next = wcnt + {{PW{1'b0}}, accept && is_wr}
                         - {{PW{1'b0}}, pop && head.wr};
    end

    // Backing store: writes land in the accept cycle, contents survive reset.
    always_ff @(posedge clk) begin
        if (accept && is_wr) begin
            store[addr] <= bus.mc_rq_data;
        end
    end

    // Fixed-latency pipeline; it never stalls because occupancy
    // accounting already reserved a FIFO slot for every accepted entry.
    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            pipe_vld <= '0;
            for (int i = 0; i < LAT; i++) begin
                pipe_ent[i] <= '0;
            end
        end else begin
            pipe_vld[0] <= accept;
            pipe_ent[0] <= new_entry;
            for (int i = 1; i < LAT; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
                pipe_ent[i] <= pipe_ent[i-1];
            end
        end
    end

    // FIFO storage; entries are only observed while the FIFO is non-empty.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= pipe_ent[LAT-1];
        end
    end

    // FIFO pointers and fill count.
    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            fifo_cnt <= fifo_cnt + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
        end
    end

    // Occupancy, outstanding-write count, back-pressure and sticky errors.
    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            occ        <= '0;
            wcnt       <= '0;
            rq_stall_q <= 1'b0;
            err_size_q <= 1'b0;
            err_ovf_q  <= 1'b0;
        end else begin
            occ        <= occ_next;
            wcnt       <= wcnt_next;
            rq_stall_q <= (occ_next >= STALL_OCC);
            err_size_q <= err_size_q | (req && (bus.mc_rq_size != 2'd3));
            err_ovf_q  <= err_ovf_q | drop;
        end
    end

    // Flush FSM state register.
    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Flush FSM next state; WAIT looks at the write count after this
    // cycle's updates so completion follows the last write-complete
    // transfer by one cycle.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (bus.mc_rq_flush) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (wcnt_next == '0) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = bus.mc_rq_flush ? WAIT : IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.mc_rq_stall       = rq_stall_q;
    assign bus.mc_rs_vld         = rs_vld;
    assign bus.mc_rs_cmd         = !rs_vld ? 3'd0 : (head.wr ? 3'd3 : 3'd2);
    assign bus.mc_rs_scmd        = 4'd0;
    assign bus.mc_rs_rtnctl      = rs_vld ? head.tag : '0;
    assign bus.mc_rs_data        = rs_vld ? head.data : 64'd0;
    assign bus.mc_rs_flush_cmplt = (state == DONE);
    assign bus.err_size          = err_size_q;
    assign bus.err_ovf           = err_ovf_q;

    assign unused_bits = ^{bus.mc_rq_scmd, bus.mc_rq_vadr[47:AW+3],
                           bus.mc_rq_vadr[2:0]};

endmodule

// File: tb/tb_mc_rsp_model.sv
// Self-checking bench for mc_rsp_model: directed scenarios followed by
// a random phase, all checked every cycle against a queue-based model.
module tb_mc_rsp_model;

    localparam int RTNCTL_WIDTH = 32;
    localparam int AW           = 10;
    localparam int LAT          = 4;
    localparam int FIFO_DEPTH   = 16;

    typedef struct {
        int          ready;
        bit          wr;
        logic [31:0] tag;
        logic [63:0] data;
    } rsp_t;

    logic clk = 1'b0;
    logic i_reset;

    mc_rsp_model_if #(.RTNCTL_WIDTH(RTNCTL_WIDTH)) bus ();

    mc_rsp_model #(
        .RTNCTL_WIDTH(RTNCTL_WIDTH),
        .AW          (AW),
        .LAT         (LAT),
        .FIFO_DEPTH  (FIFO_DEPTH)
    ) dut (
        .clk    (clk),
        .i_reset(i_reset),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    // Reference model state
    rsp_t        exp_q [$];
    logic [63:0] mem_m [1024];
    logic [9:0]  written [$];
    bit          m_stall, m_err_size, m_err_ovf, m_wait, m_cmplt;

    int          cyc, checks, errors;

    // Last observed values, captured by cycle()
    bit          seen_vld, seen_xfer, seen_cmplt, seen_stall, seen_ovf;
    logic [2:0]  seen_cmd;
    logic [63:0] seen_data;
    int          seen_cyc;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs,
                               input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h (cycle %0d)",
                   tag, obs, exp, cyc);
        end
    endtask

    task automatic applyStimulus(input bit vld, input logic [2:0] cmd,
                                 input logic [1:0] size, input logic [47:0] vadr,
                                 input logic [31:0] tag, input logic [63:0] data,
                                 input bit flush);
        bus.mc_rq_vld    = vld;
        bus.mc_rq_cmd    = cmd;
        bus.mc_rq_scmd   = 4'($urandom);
        bus.mc_rq_size   = size;
        bus.mc_rq_vadr   = vadr;
        bus.mc_rq_rtnctl = tag;
        bus.mc_rq_data   = data;
        bus.mc_rq_flush  = flush;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 3'd0, 2'd3, 48'd0, 32'd0, 64'd0, 1'b0);
    endtask

    // One clock cycle: check outputs mid-cycle, advance the model by the
    // rules of the responder, then move to just after the next edge.
    task automatic cycle();
        bit          ev;
        rsp_t        f;
        rsp_t        r;
        int          occ_now;
        int          nwr;
        logic [9:0]  a;
        logic [63:0] e_cmd;
        @(negedge clk);
        if (i_reset) begin
            exp_q.delete();
            m_stall = 0; m_err_size = 0; m_err_ovf = 0; m_wait = 0; m_cmplt = 0;
        end
        ev = (exp_q.size() > 0) && (exp_q[0].ready <= cyc);
        f.ready = 0; f.wr = 0; f.tag = '0; f.data = '0;
        if (ev) f = exp_q[0];
        e_cmd = !ev ? 64'd0 : (f.wr ? 64'd3 : 64'd2);
        checkOutput("rs_vld",    64'(bus.mc_rs_vld), 64'(ev));
        checkOutput("rs_cmd",    64'(bus.mc_rs_cmd), e_cmd);
        checkOutput("rs_scmd",   64'(bus.mc_rs_scmd), 64'd0);
        checkOutput("rs_rtnctl", 64'(bus.mc_rs_rtnctl), ev ? 64'(f.tag) : 64'd0);
        checkOutput("rs_data",   bus.mc_rs_data, ev ? f.data : 64'd0);
        checkOutput("rq_stall",  64'(bus.mc_rq_stall), 64'(m_stall));
        checkOutput("cmplt",     64'(bus.mc_rs_flush_cmplt), 64'(m_cmplt));
        checkOutput("err_size",  64'(bus.err_size), 64'(m_err_size));
        checkOutput("err_ovf",   64'(bus.err_ovf), 64'(m_err_ovf));
        seen_vld   = bus.mc_rs_vld;
        seen_xfer  = bus.mc_rs_vld && !bus.mc_rs_stall;
        seen_cmd   = bus.mc_rs_cmd;
        seen_data  = bus.mc_rs_data;
        seen_cmplt = bus.mc_rs_flush_cmplt;
        seen_stall = bus.mc_rq_stall;
        seen_ovf   = bus.err_ovf;
        seen_cyc   = cyc;
        if (!i_reset) begin
            occ_now = exp_q.size();
            if (ev && !bus.mc_rs_stall) void'(exp_q.pop_front());
            if (bus.mc_rq_vld && (bus.mc_rq_cmd == 3'd1 || bus.mc_rq_cmd == 3'd2)) begin
                if (bus.mc_rq_size != 2'd3) m_err_size = 1;
                if (occ_now < FIFO_DEPTH) begin
                    a       = bus.mc_rq_vadr[12:3];
                    r.ready = cyc + LAT + 1;
                    r.tag   = bus.mc_rq_rtnctl;
                    if (bus.mc_rq_cmd == 3'd2) begin
                        mem_m[a] = bus.mc_rq_data;
                        r.wr = 1; r.data = 64'd0;
                        written.push_back(a);
                    end else begin
                        r.wr = 0; r.data = mem_m[a];
                    end
                    exp_q.push_back(r);
                end else begin
                    m_err_ovf = 1;
                end
            end
            m_stall = (exp_q.size() >= FIFO_DEPTH - 2);
            nwr = 0;
            foreach (exp_q[i]) if (exp_q[i].wr) nwr++;
            if (m_cmplt) begin
                m_cmplt = 0;
                m_wait  = bus.mc_rq_flush;
            end else if (m_wait) begin
                if (nwr == 0) begin
                    m_cmplt = 1;
                    m_wait  = 0;
                end
            end else begin
                m_wait = bus.mc_rq_flush;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drain(input string tag);
        int n;
        idle();
        bus.mc_rs_stall = 1'b0;
        n = 0;
        while ((exp_q.size() > 0 || m_wait || m_cmplt) && n < 200) begin
            cycle();
            n++;
        end
        checkOutput({tag, "_drain"}, 64'(bus.mc_rs_vld), 64'd0);
    endtask

    int          t0, lat, cnt, first_c, last_c, cmplt_c, pulses, last_wc;
    logic [2:0]  rcmd [$];
    logic [63:0] rdat [$];
    logic [9:0]  ra;
    int          r;

    initial begin
        cyc = 0; checks = 0; errors = 0;
        i_reset = 1'b1;
        bus.mc_rs_stall = 1'b0;
        idle();
        #1;
        cycle();
        cycle();
        i_reset = 1'b0;
        cycle();

        // Write latency and write-complete format
        t0 = cyc;
        applyStimulus(1, 3'd2, 2'd3, 48'h40, 32'd7, 64'hDEAD_BEEF, 0);
        cycle();
        idle();
        lat = -1;
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (seen_vld) begin
                lat = seen_cyc - t0;
                break;
            end
        end
        checkOutput("write_latency", 64'(lat), 64'd5);
        checkOutput("write_rsp_cmd", 64'(seen_cmd), 64'd3);
        drain("t1");

        // Read-after-write ordering
        applyStimulus(1, 3'd2, 2'd3, 48'h48, 32'd1, 64'h1234, 0);
        cycle();
        applyStimulus(1, 3'd1, 2'd3, 48'h48, 32'd2, 64'd0, 0);
        cycle();
        idle();
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (seen_xfer) begin
                rcmd.push_back(seen_cmd);
                rdat.push_back(seen_data);
            end
        end
        checkOutput("raw_count", 64'(rcmd.size()), 64'd2);
        if (rcmd.size() >= 2) begin
            checkOutput("raw_first_cmd", 64'(rcmd[0]), 64'd3);
            checkOutput("raw_second_cmd", 64'(rcmd[1]), 64'd2);
            checkOutput("raw_read_data", rdat[1], 64'h1234);
        end
        drain("t2");

        // 16 reads under response stall, then release
        bus.mc_rs_stall = 1'b1;
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1, 3'd1, 2'd3, (i % 2 == 0) ? 48'h40 : 48'h48, 32'(100 + i), 64'd0, 0);
            cycle();
        end
        idle();
        cycle();
        checkOutput("stall_full", 64'(seen_stall), 64'd1);
        for (int i = 0; i < 8; i++) cycle();
        bus.mc_rs_stall = 1'b0;
        cnt = 0; first_c = -1; last_c = -1;
        for (int i = 0; i < 40; i++) begin
            cycle();
            if (seen_xfer) begin
                if (first_c < 0) first_c = seen_cyc;
                last_c = seen_cyc;
                cnt++;
            end
        end
        checkOutput("burst_count", 64'(cnt), 64'd16);
        checkOutput("burst_span", 64'(last_c - first_c), 64'd15);
        drain("t3");

        // Overflow: 17th read dropped
        bus.mc_rs_stall = 1'b1;
        for (int i = 0; i < 17; i++) begin
            applyStimulus(1, 3'd1, 2'd3, 48'h40, 32'(200 + i), 64'd0, 0);
            cycle();
        end
        idle();
        cycle();
        checkOutput("ovf_flag", 64'(seen_ovf), 64'd1);
        bus.mc_rs_stall = 1'b0;
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            cycle();
            if (seen_xfer) cnt++;
        end
        checkOutput("ovf_rsp_count", 64'(cnt), 64'd16);
        drain("t4");

        // Flush waits for three outstanding writes
        bus.mc_rs_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 3'd2, 2'd3, 48'(48'h50 + 8 * i), 32'(300 + i), 64'(i + 5), 0);
            cycle();
        end
        applyStimulus(0, 3'd0, 2'd3, 48'd0, 32'd0, 64'd0, 1);
        cycle();
        idle();
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (seen_cmplt) pulses++;
        end
        checkOutput("flush_held", 64'(pulses), 64'd0);
        bus.mc_rs_stall = 1'b0;
        pulses = 0; last_wc = -100; cmplt_c = -1;
        for (int i = 0; i < 30; i++) begin
            cycle();
            if (seen_xfer && seen_cmd == 3'd3) last_wc = seen_cyc;
            if (seen_cmplt) begin
                pulses++;
                cmplt_c = seen_cyc;
            end
        end
        checkOutput("flush_pulses", 64'(pulses), 64'd1);
        checkOutput("flush_after_wc", 64'(cmplt_c - last_wc), 64'd1);
        drain("t5");

        // Flush with nothing outstanding
        t0 = cyc;
        applyStimulus(0, 3'd0, 2'd3, 48'd0, 32'd0, 64'd0, 1);
        cycle();
        idle();
        cmplt_c = -1;
        for (int i = 0; i < 6; i++) begin
            cycle();
            if (seen_cmplt && cmplt_c < 0) cmplt_c = seen_cyc;
        end
        checkOutput("empty_flush_delay", 64'(cmplt_c - t0), 64'd2);

        // Reset while the flush is waiting
        bus.mc_rs_stall = 1'b1;
        applyStimulus(1, 3'd2, 2'd3, 48'h80, 32'd11, 64'hAA, 0);
        cycle();
        applyStimulus(1, 3'd2, 2'd3, 48'h88, 32'd12, 64'hBB, 1);
        cycle();
        idle();
        for (int i = 0; i < 3; i++) cycle();
        i_reset = 1'b1;
        cycle();
        cycle();
        i_reset = 1'b0;
        bus.mc_rs_stall = 1'b0;
        pulses = 0; cnt = 0;
        for (int i = 0; i < 15; i++) begin
            cycle();
            if (seen_cmplt) pulses++;
            if (seen_vld) cnt++;
        end
        checkOutput("reset_no_cmplt", 64'(pulses), 64'd0);
        checkOutput("reset_no_rsp", 64'(cnt), 64'd0);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            bus.mc_rs_stall = ($urandom_range(0, 99) < 30);
            r = $urandom_range(0, 99);
            if (r < 35) begin
                ra = 10'($urandom);
                applyStimulus(1, 3'd2, ($urandom_range(0, 9) == 0) ? 2'($urandom_range(0, 2)) : 2'd3,
                              {35'($urandom), ra, 3'($urandom)}, $urandom,
                              {$urandom, $urandom}, ($urandom_range(0, 99) < 3));
            end else if (r < 65 && written.size() > 0) begin
                ra = written[$urandom_range(0, written.size() - 1)];
                applyStimulus(1, 3'd1, ($urandom_range(0, 9) == 0) ? 2'($urandom_range(0, 2)) : 2'd3,
                              {35'($urandom), ra, 3'($urandom)}, $urandom,
                              {$urandom, $urandom}, ($urandom_range(0, 99) < 3));
            end else if (r < 72) begin
                applyStimulus(1, ($urandom_range(0, 1) == 0) ? 3'd0 : 3'($urandom_range(3, 7)),
                              2'($urandom), {$urandom, 16'($urandom)}, $urandom,
                              {$urandom, $urandom}, ($urandom_range(0, 99) < 3));
            end else begin
                applyStimulus(0, 3'd0, 2'd3, 48'd0, 32'd0, 64'd0, ($urandom_range(0, 99) < 3));
            end
            cycle();
        end
        drain("random");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
